mem_access_unit: RTL and testbench

- Memory-stage responder to the decoder's MemRead/MemWrite/Mmask controls; converts them into word-aligned data-bus transactions.
- Drives byte enables and lane-replicated store data; extracts and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.
- Sits between the EX/MEM pipeline register and the data memory/MMIO bus.

---
 rtl/mem_definitions.sv | 21 ++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_definitions.sv
// Shared types for the memory stage: access-size encoding from the decoder
// and the state encoding of the memory access unit.
package mem_definitions;

  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_HALF  = 3'd1,
    MEM_WORD  = 3'd2,
    MEM_UBYTE = 3'd4,
    MEM_UHALF = 3'd5
  } mem_mask_t;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_REQ  = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_t;

  localparam int MAU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store enables/replicated data,
// misalignment detection, and load-side lane extraction with extension.
module mem_lane_align
  import mem_definitions::*;
(
  input  mem_mask_t   req_mask,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  mem_mask_t   ld_mask,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Unsigned variants share the store path with their signed counterparts.
  always_comb begin
    st_be      = 4'hF;
    st_wdata   = req_data;
    misaligned = 1'b0;
    case (req_mask)
      MEM_BYTE, MEM_UBYTE: begin
        st_be    = 4'b0001 << req_lane;
        st_wdata = {4{req_data[7:0]}};
      end
      MEM_HALF, MEM_UHALF: begin
        st_be      = 4'b0011 << {req_lane[1], 1'b0};
        st_wdata   = {2{req_data[15:0]}};
        misaligned = req_lane[0];
      end
      default: misaligned = |req_lane;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_mask)
      MEM_BYTE:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_UBYTE: ld_data = {24'b0, ld_byte};
      MEM_HALF:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_UHALF: ld_data = {16'b0, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage responder: turns MemRead/MemWrite/Mmask into one word-aligned
// bus transaction, stalling upstream until it completes or times out.
module mem_access_unit
  import mem_definitions::*;
#(
  parameter int TIMEOUT_CYCLES = MAU_TIMEOUT_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  mem_mask_t         mmask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_t        state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  mem_mask_t         ld_mask_q, ld_mask_d;
  logic [1:0]        ld_lane_q, ld_lane_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              timed_out_q, timed_out_d;
  logic              illegal_q, illegal_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;
  logic        misaligned;
  logic        access, illegal, legal;

  mem_lane_align u_align (
    .req_mask   (mmask),
    .req_lane   (addr[1:0]),
    .req_data   (store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_mask    (ld_mask_q),
    .ld_lane    (ld_lane_q),
    .ld_rdata   (bus_rdata),
    .ld_data    (ld_ext)
  );

  assign access  = mem_read | mem_write;
  assign illegal = access & ((mem_read & mem_write) | misaligned);
  assign legal   = access & ~illegal;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    ld_mask_d   = ld_mask_q;
    ld_lane_d   = ld_lane_q;
    load_data_d = load_data_q;
    timed_out_d = timed_out_q;
    illegal_d   = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        if (legal) begin
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_we_d    = mem_write;
          bus_be_d    = mem_write ? st_be : 4'hF;
          bus_wdata_d = mem_write ? st_wdata : 32'b0;
          ld_mask_d   = mmask;
          ld_lane_d   = addr[1:0];
          tmo_cnt_d   = '0;
          timed_out_d = 1'b0;
          state_d     = MAU_REQ;
        end else begin
          illegal_d = illegal;
        end
      end
      MAU_REQ: begin
        // An ack on the final counted cycle still completes normally.
        if (bus_ack) begin
          if (!bus_we_q) load_data_d = ld_ext;
          state_d = MAU_DONE;
        end else if (tmo_cnt_q == CNT_LAST) begin
          timed_out_d = 1'b1;
          load_data_d = 32'b0;
          state_d     = MAU_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAU_IDLE;
      tmo_cnt_q   <= '0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0;
      bus_wdata_q <= 32'b0;
      bus_we_q    <= 1'b0;
      ld_mask_q   <= MEM_BYTE;
      ld_lane_q   <= 2'b0;
      load_data_q <= 32'b0;
      timed_out_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      ld_mask_q   <= ld_mask_d;
      ld_lane_q   <= ld_lane_d;
      load_data_q <= load_data_d;
      timed_out_q <= timed_out_d;
      illegal_q   <= illegal_d;
    end
  end

  // The issue-cycle stall is combinational, so it is gated while reset is held.
  assign stall      = rst_n & ((state_q == MAU_IDLE && legal) || state_q == MAU_REQ);
  assign bus_req    = (state_q == MAU_REQ);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == MAU_DONE) & ~bus_we_q & ~timed_out_q;
  assign fault      = illegal_q | ((state_q == MAU_DONE) & timed_out_q);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses compared against a size/offset arithmetic reference model.
module tb_mem_access_unit;
  import mem_definitions::*;

  logic        clk, rst_n;
  logic        mem_read, mem_write;
  mem_mask_t   mmask;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int checks = 0;
  int failures = 0;
  int txn_cnt = 0;
  logic req_prev = 1'b0;

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    int          lv_cnt;
    int          fault_cnt;
    int          adv_cycle;
    int          lv_cycle;
    int          fault_cycle;
    logic [31:0] ld;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    bit          hung;
    bit          unstable;
  } obs_t;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mmask(mmask), .addr(addr), .store_data(store_data), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_req && !req_prev) txn_cnt++;
    req_prev = bus_req;
  end

  // Reference: an access has a size in bytes and an offset in the word.
  function automatic void ref_model(input logic rd, input logic wr, input mem_mask_t m,
                                    input logic [31:0] a, input logic [31:0] sd,
                                    input logic [31:0] rdat, output bit legal,
                                    output logic [3:0] be, output logic [31:0] wd,
                                    output logic [31:0] ld);
    int size, off;
    bit sgn;
    longint v;
    size = (m == MEM_BYTE || m == MEM_UBYTE) ? 1 : (m == MEM_HALF || m == MEM_UHALF) ? 2 : 4;
    sgn  = (m == MEM_BYTE || m == MEM_HALF);
    off  = int'(a % 4);
    legal = !(rd && wr) && (off % size == 0);
    be = wr ? 4'(((1 << size) - 1) << ((off / size) * size)) : 4'hF;
    wd = (size == 1) ? sd[7:0] * 32'h0101_0101 : (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    v = longint'(rdat >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (sgn && ((v >> (8 * size - 1)) & 1) == 1) v = v - (longint'(1) << (8 * size));
    ld = v[31:0];
  endfunction

  // Presents one access (held while stalled), answers the bus after ack_lat
  // waiting REQ cycles (-1: never), then idles idle_after cycles.
  task automatic do_access(input logic rd, input logic wr, input mem_mask_t m,
                           input logic [31:0] a, input logic [31:0] sd, input int ack_lat,
                           input logic [31:0] rdat, input int idle_after, output obs_t o);
    bit advanced, finished, st;
    int left;
    o = '{default: 0};
    o.hung = 1'b1;
    advanced = 0; finished = 0; left = 0;
    mem_read = rd; mem_write = wr; mmask = m; addr = a; store_data = sd;
    for (int c = 0; c < 40 && !finished; c++) begin
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      #3;
      st = stall;
      if (stall) o.stall_cnt++;
      if (load_valid) begin o.lv_cnt++; o.ld = load_data; o.lv_cycle = c; end
      if (fault) begin o.fault_cnt++; o.fault_cycle = c; end
      if (bus_req) begin
        o.req_cnt++;
        if (o.req_cnt == 1) begin
          o.baddr = bus_addr; o.be = bus_be; o.wd = bus_wdata; o.we = bus_we;
        end else if (bus_addr !== o.baddr || bus_be !== o.be || bus_wdata !== o.wd || bus_we !== o.we) begin
          o.unstable = 1'b1;
        end
        if (ack_lat >= 0 && o.req_cnt == ack_lat + 1) begin
          bus_ack = 1'b1;
          bus_rdata = rdat;
        end
      end
      @(posedge clk); #1;
      if (!advanced) begin
        if (!st) begin
          advanced = 1; o.adv_cycle = c;
          mem_read = 1'b0; mem_write = 1'b0;
          left = idle_after;
          if (left == 0) finished = 1;
        end
      end else begin
        left--;
        if (left == 0) finished = 1;
      end
    end
    bus_ack = 1'b0;
    if (finished) o.hung = 1'b0;
  endtask

  task automatic test_reset();
    mem_read = 1'b1; mmask = MEM_WORD; addr = 32'h100;
    #1;
    checks++;
    if ({stall, bus_req, load_valid, fault, bus_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got stall=%b req=%b lv=%b fault=%b we=%b want all 0",
               stall, bus_req, load_valid, fault, bus_we);
    end
    checks++;
    if ({bus_addr, bus_be, bus_wdata, load_data} !== 100'b0) begin
      failures++;
      $display("FAIL reset_data got addr=%h be=%h wdata=%h ld=%h want 0", bus_addr, bus_be, bus_wdata, load_data);
    end
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    obs_t o;
    do_access(1'b0, 1'b1, MEM_BYTE, 32'h1003, 32'h0000_00A5, 1, 32'h0, 2, o);
    checks++;
    if ({o.baddr, o.be, o.wd, o.we} !== {32'h1000, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin
      failures++;
      $display("FAIL sb_bus got addr=%h be=%b wdata=%h we=%b want 1000 1000 a5a5a5a5 1", o.baddr, o.be, o.wd, o.we);
    end
    checks++;
    if (o.stall_cnt != 3 || o.lv_cnt != 0 || o.req_cnt != 2 || o.hung || o.unstable) begin
      failures++;
      $display("FAIL sb_timing got stall=%0d lv=%0d req=%0d hung=%0d unstable=%0d want 3 0 2 0 0",
               o.stall_cnt, o.lv_cnt, o.req_cnt, o.hung, o.unstable);
    end
  endtask

  task automatic test_loads();
    mem_mask_t   ms [4] = '{MEM_BYTE, MEM_UBYTE, MEM_HALF, MEM_UHALF};
    logic [31:0] as [4] = '{32'h2002, 32'h2002, 32'h3002, 32'h3002};
    logic [31:0] rs [4] = '{32'h0080_FF00, 32'h0080_FF00, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] es [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 1'b0, ms[i], as[i], 32'h0, 0, rs[i], 2, o);
      checks++;
      if (o.ld !== es[i] || o.lv_cnt != 1 || o.lv_cycle != o.adv_cycle) begin
        failures++;
        $display("FAIL load_%s got data=%h pulses=%0d at=%0d want data=%h pulses=1 at=%0d",
                 ms[i].name(), o.ld, o.lv_cnt, o.lv_cycle, es[i], o.adv_cycle);
      end
      checks++;
      if (o.stall_cnt != 2 || o.req_cnt != 1 || o.be !== 4'hF || o.we !== 1'b0 || o.baddr !== (as[i] & ~32'h3)) begin
        failures++;
        $display("FAIL load_bus_%0d got stall=%0d req=%0d be=%h we=%b addr=%h want 2 1 f 0 %h",
                 i, o.stall_cnt, o.req_cnt, o.be, o.we, o.baddr, as[i] & ~32'h3);
      end
    end
  endtask

  task automatic test_illegal();
    logic        rds [3] = '{1'b1, 1'b0, 1'b1};
    logic        wrs [3] = '{1'b0, 1'b1, 1'b1};
    mem_mask_t   ms  [3] = '{MEM_WORD, MEM_HALF, MEM_WORD};
    logic [31:0] as  [3] = '{32'h4001, 32'h4003, 32'h4000};
    obs_t o;
    int t0;
    for (int i = 0; i < 3; i++) begin
      t0 = txn_cnt;
      do_access(rds[i], wrs[i], ms[i], as[i], 32'h1234_5678, 0, 32'h0, 2, o);
      checks++;
      if (o.req_cnt != 0 || o.stall_cnt != 0 || o.fault_cnt != 1 || o.fault_cycle != 1 ||
          o.lv_cnt != 0 || txn_cnt != t0) begin
        failures++;
        $display("FAIL illegal_%0d got req=%0d stall=%0d faults=%0d at=%0d lv=%0d want 0 0 1 1 0",
                 i, o.req_cnt, o.stall_cnt, o.fault_cnt, o.fault_cycle, o.lv_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1'b1, 1'b0, MEM_WORD, 32'h5000, 32'h0, -1, 32'h0, 2, o);
    checks++;
    if (o.req_cnt != 16 || o.stall_cnt != 17 || o.fault_cnt != 1 || o.fault_cycle != o.adv_cycle ||
        o.lv_cnt != 0 || o.hung) begin
      failures++;
      $display("FAIL timeout got req=%0d stall=%0d faults=%0d at=%0d lv=%0d hung=%0d want 16 17 1 %0d 0 0",
               o.req_cnt, o.stall_cnt, o.fault_cnt, o.fault_cycle, o.lv_cnt, o.hung, o.adv_cycle);
    end
    checks++;
    if (load_data !== 32'h0) begin
      failures++;
      $display("FAIL timeout_data got %h want 0", load_data);
    end
  endtask

  task automatic test_ack_idle();
    int bad = 0;
    bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      if (load_valid || stall || bus_req || fault) bad++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ack_idle got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_req();
    int bad = 0;
    mem_read = 1'b1; mem_write = 1'b0; mmask = MEM_WORD; addr = 32'h6000;
    @(posedge clk); #1;
    #2;
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_start got req=%b want 1", bus_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, load_valid, fault, bus_we, bus_be} !== 9'b0 || bus_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_req_reset got req=%b stall=%b lv=%b fault=%b we=%b be=%h addr=%h want 0",
               bus_req, stall, load_valid, fault, bus_we, bus_be, bus_addr);
    end
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      if (load_valid || bus_req || fault) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_req_abandon got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [31:0] sd;
    int t0;
    sd = $urandom;
    t0 = txn_cnt;
    do_access(1'b1, 1'b0, MEM_WORD, 32'h7000, 32'h0, 0, 32'hCAFE_F00D, 0, o1);
    do_access(1'b0, 1'b1, MEM_WORD, 32'h7004, sd, 0, 32'h0, 2, o2);
    checks++;
    if (o1.ld !== 32'hCAFE_F00D || o1.lv_cnt != 1) begin
      failures++;
      $display("FAIL b2b_load got data=%h pulses=%0d want cafef00d 1", o1.ld, o1.lv_cnt);
    end
    checks++;
    if ({o2.baddr, o2.be, o2.wd, o2.we} !== {32'h7004, 4'hF, sd, 1'b1} || o2.lv_cnt != 0) begin
      failures++;
      $display("FAIL b2b_store got addr=%h be=%h wdata=%h we=%b lv=%0d want 7004 f %h 1 0",
               o2.baddr, o2.be, o2.wd, o2.we, o2.lv_cnt, sd);
    end
    checks++;
    if (txn_cnt - t0 != 2) begin
      failures++;
      $display("FAIL b2b_txns got %0d want 2", txn_cnt - t0);
    end
  endtask

  task automatic test_random();
    mem_mask_t masks [5] = '{MEM_BYTE, MEM_HALF, MEM_WORD, MEM_UBYTE, MEM_UHALF};
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      mem_mask_t m;
      logic [31:0] a, sd, rdat, wd, ld;
      logic [3:0] be;
      bit legal;
      int lat, sel;
      sel  = $urandom_range(0, 9);
      rd   = (sel < 5) || (sel == 9);
      wr   = (sel >= 5);
      m    = masks[$urandom_range(0, 4)];
      a    = $urandom & 32'h0000_FFFF;
      sd   = $urandom;
      rdat = $urandom;
      lat  = $urandom_range(0, 3);
      ref_model(rd, wr, m, a, sd, rdat, legal, be, wd, ld);
      do_access(rd, wr, m, a, sd, lat, rdat, 1, o);
      if (legal) begin
        checks++;
        if (o.req_cnt != lat + 1 || o.stall_cnt != lat + 2 || o.lv_cnt != int'(rd) ||
            o.fault_cnt != 0 || o.hung || o.unstable) begin
          failures++;
          $display("FAIL rand_timing_%0d got req=%0d stall=%0d lv=%0d fault=%0d hung=%0d unstable=%0d want %0d %0d %0d 0 0 0",
                   i, o.req_cnt, o.stall_cnt, o.lv_cnt, o.fault_cnt, o.hung, o.unstable, lat + 1, lat + 2, int'(rd));
        end
        checks++;
        if (o.baddr !== (a & ~32'h3) || o.be !== be || o.we !== wr || (wr && o.wd !== wd)) begin
          failures++;
          $display("FAIL rand_bus_%0d got addr=%h be=%b we=%b wdata=%h want %h %b %b %h",
                   i, o.baddr, o.be, o.we, o.wd, a & ~32'h3, be, wr, wd);
        end
        if (rd) begin
          checks++;
          if (o.ld !== ld) begin
            failures++;
            $display("FAIL rand_load_%0d %s addr=%h rdata=%h got %h want %h", i, m.name(), a, rdat, o.ld, ld);
          end
        end
      end else begin
        checks++;
        if (o.req_cnt != 0 || o.stall_cnt != 0 || o.fault_cnt != 1 || o.lv_cnt != 0) begin
          failures++;
          $display("FAIL rand_illegal_%0d got req=%0d stall=%0d fault=%0d lv=%0d want 0 0 1 0",
                   i, o.req_cnt, o.stall_cnt, o.fault_cnt, o.lv_cnt);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mmask = MEM_WORD;
    addr = 32'h0; store_data = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sb();
    test_loads();
    test_illegal();
    test_timeout();
    test_ack_idle();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
